// File: rtl/aes_pkg.sv
// aes_pkg: shared types, tables and byte-level helpers for the AES cipher.
//   byte_t / word_t / state_t : AES byte, 32-bit word and 16-byte state.
//   state_t element n is byte n in FIPS-197 order. Byte 4c+r is row r,
//   column c. Word MSB is byte 0 of the word.
//   fsm_state_e : cipher FSM states.
//   sbox, xtime, sub_word, rot_word, mix_column, aes_round : round helpers.
package aes_pkg;

    typedef logic [7:0]         byte_t;
    typedef logic [31:0]        word_t;
    typedef logic [0:15][7:0]   state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t sub_word(input word_t x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic word_t mix_column(input word_t c);
        byte_t b0, b1, b2, b3;
        b0 = c[31:24];
        b1 = c[23:16];
        b2 = c[15:8];
        b3 = c[7:0];
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    // One full round: SubBytes, ShiftRows, MixColumns (skipped when last),
    // AddRoundKey. Row r of column c takes the byte from column (c+r) mod 4.
    function automatic state_t aes_round(input state_t s, input state_t rk, input logic last);
        state_t sr;
        state_t mc;
        word_t  col;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sbox(s[4*((c+r)%4)+r]);
            end
        end
        mc = sr;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                col = mix_column({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
                mc[4*c]   = col[31:24];
                mc[4*c+1] = col[23:16];
                mc[4*c+2] = col[15:8];
                mc[4*c+3] = col[7:0];
            end
        end
        return mc ^ rk;
    endfunction

endpackage

// File: rtl/aes_key_window.sv
// aes_key_window: sliding window over the AES key schedule.
//   clk, rst   : clock, asynchronous active-high reset (clears W, phase, Rcon).
//   load       : take key as w[0..Nk-1] and advance once in the same edge.
//   advance    : slide the held window forward by four words.
//   key        : cipher key, bits 0..31 are w[0].
//   round_key  : W words 0..3, word 0 in the top 32 bits.
module aes_key_window
    import aes_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [0:Nk*32-1]  key,
    output logic [127:0]      round_key
);

    word_t      w [Nk];
    logic [2:0] phase;
    byte_t      rcon;

    // e[0..Nk-1] is the source window, e[Nk..Nk+3] the four new words.
    word_t      e [Nk+4];
    word_t      nxt_w [Nk];
    word_t      t;
    int         p;
    int         pos;
    byte_t      rc;
    logic       use_rcon;
    logic [2:0] nxt_phase;
    byte_t      nxt_rcon;

    always_comb begin
        t        = '0;
        pos      = 0;
        use_rcon = 1'b0;
        p        = load ? 0 : int'(phase);
        rc       = load ? 8'h01 : rcon;
        for (int i = 0; i < Nk; i++) begin
            e[i] = load ? word_t'(key[32*i +: 32]) : w[i];
        end
        for (int k = 0; k < 4; k++) begin
            // New word index i satisfies i mod Nk == (phase + k) mod Nk.
            pos = (p + k) % Nk;
            t   = e[Nk+k-1];
            if (pos == 0) begin
                t        = sub_word(rot_word(t)) ^ {rc, 24'h000000};
                use_rcon = 1'b1;
            end else if (Nk == 8 && pos == 4) begin
                t = sub_word(t);
            end
            e[Nk+k] = e[k] ^ t;
        end
        for (int i = 0; i < Nk; i++) begin
            nxt_w[i] = e[i+4];
        end
        nxt_phase = 3'((p + 4) % Nk);
        // At most one Rcon use per step for every legal Nk.
        nxt_rcon  = use_rcon ? xtime(rc) : rc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Nk; i++) begin
                w[i] <= '0;
            end
            phase <= '0;
            rcon  <= '0;
        end else if (load || advance) begin
            w     <= nxt_w;
            phase <= nxt_phase;
            rcon  <= nxt_rcon;
        end
    end

    assign round_key = {w[0], w[1], w[2], w[3]};

endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES forward cipher, one round per clock.
//   clk, rst             : clock, asynchronous active-high reset.
//   in_valid / in_ready  : job handshake; in and key sampled on accept.
//   in, key              : plaintext block and cipher key (FIPS-197 order).
//   out_valid / out_ready: result handshake; out held until taken.
//   out                  : ciphertext, same byte order as in.
//   fsm_state            : current FSM state, for observation.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A valid, once raised, stays high with stable data until that transfer.
// in_ready depends combinationally on out_ready only, never on in_valid.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:127]      in,
    input  logic [0:Nk*32-1]  key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:127]      out,
    output fsm_state_e        fsm_state
);

    if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
        $error("aes_cipher_iter: Nk must be 4, 6 or 8");
    end
    if (Nr != Nk + 6) begin : g_bad_nr
        $error("aes_cipher_iter: Nr must equal Nk+6");
    end

    fsm_state_e state;
    logic [3:0] round;
    state_t     data;
    state_t     rk;
    state_t     round_out;
    logic       last_round;
    logic       accept;
    logic       advance;

    assign in_ready   = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_round = (round == 4'(Nr));
    // The final round's key is already in the window, so the last RUN edge
    // does not slide it; this keeps Rcon within the schedule's ten values.
    assign advance    = (state == ST_RUN) && !last_round;
    assign round_out  = aes_round(data, rk, last_round);
    assign fsm_state  = state;

    aes_key_window #(
        .Nk (Nk)
    ) u_key_window (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .advance   (advance),
        .key       (key),
        .round_key (rk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            round     <= '0;
            data      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data  <= in ^ key[0:127];
                        round <= 4'd1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_round) begin
                        out       <= round_out;
                        out_valid <= 1'b1;
                        round     <= '0;
                        state     <= ST_DONE;
                    end else begin
                        data  <= round_out;
                        round <= round + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            data  <= in ^ key[0:127];
                            round <= 4'd1;
                            state <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
module tb_aes_cipher_iter;
    import aes_pkg::*;

    localparam logic [0:127] A_IN   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] A_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] A_EXP  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] C_IN   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_EXP = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:191] C2_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [0:127] C2_EXP = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:255] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] C3_EXP = 128'h8ea2b7ca516745bfeafc49904b496089;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic         v4 = 1'b0, r4, ov4, or4 = 1'b1;
    logic [0:127] in4 = '0, key4 = '0, out4;
    fsm_state_e   st4;
    logic         v6 = 1'b0, r6, ov6, or6 = 1'b1;
    logic [0:127] in6 = '0, out6;
    logic [0:191] key6 = '0;
    fsm_state_e   st6;
    logic         v8 = 1'b0, r8, ov8, or8 = 1'b1;
    logic [0:127] in8 = '0, out8;
    logic [0:255] key8 = '0;
    fsm_state_e   st8;

    aes_cipher_iter #(.Nk(4), .Nr(10)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in(in4), .key(key4),
        .out_valid(ov4), .out_ready(or4), .out(out4), .fsm_state(st4));
    aes_cipher_iter #(.Nk(6), .Nr(12)) dut6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ready(r6), .in(in6), .key(key6),
        .out_valid(ov6), .out_ready(or6), .out(out6), .fsm_state(st6));
    aes_cipher_iter #(.Nk(8), .Nr(14)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in(in8), .key(key8),
        .out_valid(ov8), .out_ready(or8), .out(out8), .fsm_state(st8));

    // ---------------- driver tasks ----------------
    // Presents one job to the Nk=4 core; returns at the negedge after accept.
    task automatic start4(input logic [0:127] p, input logic [0:127] k);
        @(negedge clk);
        v4 = 1'b1; in4 = p; key4 = k;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
    endtask

    // Counts edges until out_valid is seen (-1 on timeout).
    task automatic wait_out4(output int lat);
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (ov4 === 1'b1) lat = c;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (r4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready4: got %b want 1", r4); end
        n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid4: got %b want 0", ov4); end
        n_tests++; if (out4 !== 128'h0) begin n_fail++; $display("FAIL reset_out4: got %h want 0", out4); end
        n_tests++; if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL reset_state4: got %0d want %0d", st4, ST_IDLE); end
        n_tests++; if (r6 !== 1'b1 || ov6 !== 1'b0) begin n_fail++; $display("FAIL reset_6: ready %b valid %b want 1 0", r6, ov6); end
        n_tests++; if (r8 !== 1'b1 || ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_8: ready %b valid %b want 1 0", r8, ov8); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_key_sizes();
        int lat4, lat6, lat8;
        logic [0:127] got4, got6, got8;
        lat4 = -1; lat6 = -1; lat8 = -1;
        got4 = '0; got6 = '0; got8 = '0;
        or4 = 1'b1; or6 = 1'b1; or8 = 1'b1;
        v4 = 1'b1; in4 = A_IN; key4 = A_KEY;
        v6 = 1'b1; in6 = C_IN; key6 = C2_KEY;
        v8 = 1'b1; in8 = C_IN; key8 = C3_KEY;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0; v6 = 1'b0; v8 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ov4 === 1'b1 && lat4 < 0) begin lat4 = c; got4 = out4; end
            if (ov6 === 1'b1 && lat6 < 0) begin lat6 = c; got6 = out6; end
            if (ov8 === 1'b1 && lat8 < 0) begin lat8 = c; got8 = out8; end
        end
        n_tests++; if (lat4 != 10) begin n_fail++; $display("FAIL aes128_latency: got %0d want 10", lat4); end
        n_tests++; if (got4 !== A_EXP) begin n_fail++; $display("FAIL aes128_out: got %h want %h", got4, A_EXP); end
        n_tests++; if (lat6 != 12) begin n_fail++; $display("FAIL aes192_latency: got %0d want 12", lat6); end
        n_tests++; if (got6 !== C2_EXP) begin n_fail++; $display("FAIL aes192_out: got %h want %h", got6, C2_EXP); end
        n_tests++; if (lat8 != 14) begin n_fail++; $display("FAIL aes256_latency: got %0d want 14", lat8); end
        n_tests++; if (got8 !== C3_EXP) begin n_fail++; $display("FAIL aes256_out: got %h want %h", got8, C3_EXP); end
        n_tests++; if (st4 !== ST_IDLE || st6 !== ST_IDLE || st8 !== ST_IDLE) begin
            n_fail++; $display("FAIL key_sizes_idle: got %0d %0d %0d want 0 0 0", st4, st6, st8);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        or4 = 1'b1;
        @(negedge clk);
        v4 = 1'b1; in4 = C_IN; key4 = C1_KEY;
        @(posedge clk);
        @(negedge clk);
        in4 = A_IN; key4 = A_KEY;          // in_valid stays high for the next job
        wait_out4(lat);
        n_tests++; if (lat != 10) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 10", lat); end
        n_tests++; if (out4 !== C1_EXP) begin n_fail++; $display("FAIL b2b_first_out: got %h want %h", out4, C1_EXP); end
        n_tests++; if (r4 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b want 1", r4); end
        @(negedge clk);
        v4 = 1'b0;
        n_tests++; if (ov4 !== 1'b0 || st4 !== ST_RUN) begin
            n_fail++; $display("FAIL b2b_second_accept: valid %b state %0d want 0 %0d", ov4, st4, ST_RUN);
        end
        wait_out4(lat);
        n_tests++; if (lat != 10) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 10", lat); end
        n_tests++; if (out4 !== A_EXP) begin n_fail++; $display("FAIL b2b_second_out: got %h want %h", out4, A_EXP); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad_stable, bad_ready, bad_valid, xfers;
        bad_stable = 0; bad_ready = 0; bad_valid = 0; xfers = 0;
        or4 = 1'b0;
        start4(C_IN, C1_KEY);
        wait_out4(lat);
        n_tests++; if (lat != 10 || out4 !== C1_EXP) begin
            n_fail++; $display("FAIL bp_result: lat %0d out %h want 10 %h", lat, out4, C1_EXP);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out4 !== C1_EXP) bad_stable++;
            if (r4 !== 1'b0) bad_ready++;
            if (ov4 !== 1'b1) bad_valid++;
        end
        n_tests++; if (bad_stable != 0) begin n_fail++; $display("FAIL bp_out_stable: %0d bad cycles want 0", bad_stable); end
        n_tests++; if (bad_ready != 0) begin n_fail++; $display("FAIL bp_in_ready_low: %0d bad cycles want 0", bad_ready); end
        n_tests++; if (bad_valid != 0) begin n_fail++; $display("FAIL bp_valid_held: %0d bad cycles want 0", bad_valid); end
        or4 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ov4 === 1'b1 && or4 === 1'b1) xfers++;
            @(negedge clk);
        end
        n_tests++; if (xfers != 1) begin n_fail++; $display("FAIL bp_single_transfer: got %0d want 1", xfers); end
        n_tests++; if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL bp_idle_after: got %0d want %0d", st4, ST_IDLE); end
    endtask

    task automatic test_reset_mid_job();
        int lat;
        or4 = 1'b1;
        start4(A_IN, A_KEY);
        repeat (4) @(negedge clk);         // round counter now at 5
        rst = 1'b1;
        #1;
        n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", ov4); end
        n_tests++; if (r4 !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", r4); end
        n_tests++; if (out4 !== 128'h0) begin n_fail++; $display("FAIL midrst_out: got %h want 0", out4); end
        n_tests++; if (st4 !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want %0d", st4, ST_IDLE); end
        @(negedge clk);
        rst = 1'b0;
        or4 = 1'b0;
        start4(A_IN, A_KEY);
        wait_out4(lat);
        n_tests++; if (lat != 10) begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d want 10", lat); end
        n_tests++; if (out4 !== A_EXP) begin n_fail++; $display("FAIL midrst_fresh_out: got %h want %h", out4, A_EXP); end
        @(negedge clk);
        rst = 1'b1;                         // reset while a result is held
        #1;
        n_tests++; if (ov4 !== 1'b0 || out4 !== 128'h0) begin
            n_fail++; $display("FAIL donerst: valid %b out %h want 0 0", ov4, out4);
        end
        @(negedge clk);
        rst = 1'b0;
        or4 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_input_changes();
        int lat;
        logic [0:127] got;
        lat = -1; got = '0;
        or4 = 1'b1;
        start4(A_IN, A_KEY);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (ov4 === 1'b1) begin
                lat = c; got = out4;
            end
            in4  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key4 = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        n_tests++; if (lat != 10) begin n_fail++; $display("FAIL rand_inputs_latency: got %0d want 10", lat); end
        n_tests++; if (got !== A_EXP) begin n_fail++; $display("FAIL rand_inputs_out: got %h want %h", got, A_EXP); end
        @(negedge clk);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_key_sizes();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_job();
        test_input_changes();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
